// File: rtl/p3_execute_pkg.sv
// Shared constants for the p3 execute stage: opcodes, class codes, phase and FSM encoding,
// plus the single-bit shift step used by both the serial and barrel shifters.
package p3_execute_pkg;

  localparam logic [2:0] EXEC_PHASE = 3'b010;

  localparam logic [1:0] CLS_LD  = 2'b00;
  localparam logic [1:0] CLS_ST  = 2'b01;
  localparam logic [1:0] CLS_IMM = 2'b10;
  localparam logic [1:0] CLS_ALU = 2'b11;

  localparam logic [2:0] SUB_LI   = 3'b000;
  localparam logic [2:0] SUB_ADDI = 3'b001;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLR = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_IN  = 4'b1100;
  localparam logic [3:0] OP_OUT = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // One shift step; kind is op[1:0] (SLL, SLR, SRL, SRA). Returns {carry, value}.
  function automatic logic [16:0] shift1(input logic [15:0] v, input logic [1:0] kind);
    case (kind)
      2'b00:   shift1 = {v[15], v[14:0], 1'b0};
      2'b01:   shift1 = {v[15], v[14:0], v[15]};
      2'b10:   shift1 = {v[0], 1'b0, v[15:1]};
      default: shift1 = {v[0], v[15], v[15:1]};
    endcase
  endfunction

endpackage

// File: rtl/p3_alu.sv
// Combinational ALU for all non-shift, flag-producing and address ops of the execute stage.
module p3_alu
  import p3_execute_pkg::*;
(
  input  logic [1:0]  cls,
  input  logic [2:0]  sub,
  input  logic [3:0]  op,
  input  logic [7:0]  imm,
  input  logic [15:0] ar,
  input  logic [15:0] br,
  input  logic [15:0] in_port,
  output logic [15:0] res,
  output logic        s,
  output logic        z,
  output logic        c,
  output logic        v,
  output logic        wr_dr,
  output logic        wr_flags
);

  logic [15:0] sext, opb;
  logic [16:0] add17, sub17;
  logic        add_v, sub_v;

  // ADD/ADDI/LD/ST share one adder; the second operand is ar only for class 11.
  assign sext  = {{8{imm[7]}}, imm};
  assign opb   = (cls == CLS_ALU) ? ar : sext;
  assign add17 = {1'b0, br} + {1'b0, opb};
  assign sub17 = {1'b0, br} - {1'b0, ar};
  assign add_v = (br[15] == opb[15]) && (add17[15] != br[15]);
  assign sub_v = (br[15] != ar[15]) && (sub17[15] != br[15]);

  always_comb begin
    res      = 16'h0000;
    c        = 1'b0;
    v        = 1'b0;
    wr_dr    = 1'b0;
    wr_flags = 1'b0;
    case (cls)
      CLS_LD, CLS_ST: begin
        res   = add17[15:0];
        wr_dr = 1'b1;
      end
      CLS_IMM: begin
        if (sub == SUB_LI) begin
          res   = sext;
          wr_dr = 1'b1;
        end else if (sub == SUB_ADDI) begin
          res      = add17[15:0];
          c        = add17[16];
          v        = add_v;
          wr_dr    = 1'b1;
          wr_flags = 1'b1;
        end
      end
      default: begin
        case (op)
          OP_ADD: begin
            res = add17[15:0]; c = add17[16]; v = add_v;
            wr_dr = 1'b1; wr_flags = 1'b1;
          end
          OP_SUB, OP_CMP: begin
            res = sub17[15:0]; c = sub17[16]; v = sub_v;
            wr_dr = (op == OP_SUB); wr_flags = 1'b1;
          end
          OP_AND: begin res = br & ar; wr_dr = 1'b1; wr_flags = 1'b1; end
          OP_OR:  begin res = br | ar; wr_dr = 1'b1; wr_flags = 1'b1; end
          OP_XOR: begin res = br ^ ar; wr_dr = 1'b1; wr_flags = 1'b1; end
          OP_MOV: begin res = ar;      wr_dr = 1'b1; wr_flags = 1'b1; end
          OP_IN:  begin res = in_port; wr_dr = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

  assign s = res[15];
  assign z = (res == 16'h0000);

endmodule

// File: rtl/p3_execute.sv
// Execute stage of the phased 16-bit processor. Define P3_SERIAL_SHIFT_EN for the
// one-bit-per-cycle shifter with stall handshake; otherwise a barrel shifter is used.
module p3_execute
  import p3_execute_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       phase_counter,
  input  logic [15:0]      instruction_register_wire,
  input  logic [WIDTH-1:0] ar,
  input  logic [WIDTH-1:0] br,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] dr,
  output logic             flag_s,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [WIDTH-1:0] out_port,
  output logic             out_strobe,
  output logic             exec_busy,
  output logic             halt
);

  logic [1:0]  cls;
  logic [3:0]  op, d;
  logic        is_alu_cls, is_shift, idle, start, done_q;
  logic        serial_start, sh_last;
  logic [16:0] sh_now, sh_step, sh_fin;
  logic [15:0] alu_res;
  logic        alu_s, alu_z, alu_c, alu_v, alu_wr_dr, alu_wr_flags;
  logic        unused_rd_sel;

  assign cls           = instruction_register_wire[15:14];
  assign op            = instruction_register_wire[7:4];
  assign d             = instruction_register_wire[3:0];
  assign unused_rd_sel = ^instruction_register_wire[10:8];
  assign is_alu_cls    = (cls == CLS_ALU);
  assign is_shift      = is_alu_cls &&
                         (op == OP_SLL || op == OP_SLR || op == OP_SRL || op == OP_SRA);

  p3_alu u_alu (
    .cls(cls), .sub(instruction_register_wire[13:11]), .op(op),
    .imm(instruction_register_wire[7:0]), .ar(ar), .br(br), .in_port(in_port),
    .res(alu_res), .s(alu_s), .z(alu_z), .c(alu_c), .v(alu_v),
    .wr_dr(alu_wr_dr), .wr_flags(alu_wr_flags)
  );

`ifdef P3_SERIAL_SHIFT_EN
  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [1:0]  kind_q;
  logic [15:0] sh_q;
  logic [16:0] sh_first;

  assign idle         = (state == ST_IDLE);
  assign serial_start = start && is_shift && (d > 4'd1);
  assign sh_first     = shift1(br, op[1:0]);
  assign sh_now       = (d == 4'd0) ? {1'b0, br} : sh_first;
  assign sh_step      = shift1(sh_q, kind_q);
  assign sh_last      = (state == ST_SHIFT) && (cnt == 4'd1);
  assign exec_busy    = !reset && (serial_start || (state == ST_SHIFT && cnt > 4'd1));

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (serial_start) state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt == 4'd1) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // The start cycle already performs shift 1, so d-1 steps remain.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= 4'd0;
      kind_q <= 2'b00;
      sh_q   <= 16'h0000;
    end else if (serial_start) begin
      cnt    <= d - 4'd1;
      kind_q <= op[1:0];
      sh_q   <= sh_first[15:0];
    end else if (state == ST_SHIFT) begin
      cnt    <= cnt - 4'd1;
      sh_q   <= sh_step[15:0];
    end
  end
`else
  assign idle         = 1'b1;
  assign serial_start = 1'b0;
  assign sh_last      = 1'b0;
  assign sh_step      = 17'h0;
  assign exec_busy    = 1'b0;

  always_comb begin
    sh_now = {1'b0, br};
    for (int i = 0; i < 15; i++)
      if (i < int'(d)) sh_now = shift1(sh_now[15:0], op[1:0]);
  end
`endif

  assign start  = idle && (phase_counter == EXEC_PHASE) && !done_q;
  assign sh_fin = sh_last ? sh_step : sh_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      dr         <= '0;
      flag_s     <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      out_port   <= '0;
      out_strobe <= 1'b0;
      halt       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (phase_counter != EXEC_PHASE) done_q <= 1'b0;
      if (start && !serial_start) begin
        done_q <= 1'b1;
        if (!is_shift) begin
          if (alu_wr_dr) dr <= alu_res;
          if (alu_wr_flags) begin
            flag_s <= alu_s;
            flag_z <= alu_z;
            flag_c <= alu_c;
            flag_v <= alu_v;
          end
        end
        if (is_alu_cls && op == OP_OUT) begin
          out_port   <= ar;
          out_strobe <= 1'b1;
        end
        if (is_alu_cls && op == OP_HLT) halt <= 1'b1;
      end
      if ((start && !serial_start && is_shift) || sh_last) begin
        done_q <= 1'b1;
        dr     <= sh_fin[15:0];
        flag_s <= sh_fin[15];
        flag_z <= (sh_fin[15:0] == 16'h0000);
        flag_c <= sh_fin[16];
        flag_v <= 1'b0;
      end
    end
  end

endmodule

// File: doc/p3_execute.md
# p3_execute

Third stage of the phased 16-bit SIMPLE-style processor. It consumes the operand registers `ar` and `br` produced by the decode stage, together with the instruction word. When `phase_counter` is 3'b010 it computes the ALU, shift or address result into `dr` and updates the S/Z/C/V flags. Shifts can optionally run serially, one bit per cycle, with a stall handshake to the phase controller.

## Interface
- WIDTH, 16, datapath width; only 16 is supported.
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- phase_counter  in  3  stage is active when the value is 3'b010.
- instruction_register_wire  in  16  current instruction.
- ar  in  16  value of r[IR[13:11]] (rs).
- br  in  16  value of r[IR[10:8]] (rd).
- in_port  in  16  external input sampled by IN.
- dr  out  16  result register.
- flag_s, flag_z, flag_c, flag_v  out  1 each  condition flags.
- out_port  out  16  register written by OUT.
- out_strobe  out  1  one-cycle pulse when out_port is written.
- exec_busy  out  1  combinational; while high, the phase controller holds phase 3'b010.
- halt  out  1  sticky; set by HLT.

## Operation
- All outputs reset to 0 and the FSM resets to IDLE. exec_busy is forced to 0 while reset is high.
- Reset during SHIFT aborts the shift; dr and the flags return to 0.
- A start is IDLE && phase_counter==3'b010 && !done_q. done_q sets when an instruction completes and clears whenever phase != 3'b010. Holding phase 010 therefore never re-executes an instruction.
- Class 11 (IR[15:14]), op = IR[7:4], d = IR[3:0]. Arithmetic is computed as br OP ar.
  - 0000 ADD: C = carry out; V = (br[15]==ar[15]) && (res[15]!=br[15]).
  - 0001 SUB: C = borrow (br < ar unsigned); V = (br[15]!=ar[15]) && (res[15]!=br[15]).
  - 0010 AND, 0011 OR, 0100 XOR: C = V = 0.
  - 0101 CMP: sets flags as for SUB; dr holds its value.
  - 0110 MOV: dr = ar; S and Z from ar; C = V = 0.
  - 1000 SLL, 1001 SLR (rotate left), 1010 SRL, 1011 SRA: shift br by d.
    - C = last bit shifted out; for SLR, C = final bit 0. V = 0.
    - d = 0 gives dr = br and C = 0.
  - 1100 IN: dr = in_port; flags hold.
  - 1101 OUT: out_port = ar; out_strobe is pulsed; dr and flags hold.
  - 1111 HLT: halt = 1; dr and flags hold.
  - All other op codes: no operation.
- S = res[15] and Z = (res == 0) for every flag-updating op.
- Class 00 (LD) and 01 (ST): dr = br + sext(IR[7:0]); flags hold.
- Class 10, IR[13:11] = 000 (LI): dr = sext(IR[7:0]); flags hold.
- Class 10, IR[13:11] = 001 (ADDI): dr = br + sext(IR[7:0]); flags as for ADD.
- Other class 10 encodings: no operation.
- All arithmetic is mod 2^16. Carry uses a 17-bit sum.

## Timing
- Non-shift ops and shifts with d ≤ 1: dr, flags, out_port, out_strobe and halt update on the posedge of the start cycle (1-cycle latency). exec_busy stays 0.
- Serial shifts with d ≥ 2 (macro defined):
  - Start cycle: load the shift register with br and perform shift 1. cnt = d-1; go to SHIFT.
  - SHIFT: one shift per cycle, decrementing cnt. When cnt reaches 0, latch dr and flags; go to IDLE; set done_q.
  - exec_busy = (start && serial shift && d ≥ 2) || (SHIFT && cnt > 1).
  - Phase 010 therefore lasts exactly d cycles, of which d-1 are stalls.
- States are IDLE and SHIFT only.
- halt stays set until reset.

## Configuration
- P3_SERIAL_SHIFT_EN defined: the iterative shifter and SHIFT state are present, as described above.
- P3_SERIAL_SHIFT_EN undefined: a single-cycle barrel shifter is used, the SHIFT state is absent and exec_busy is tied to 0.
- Results and flags are identical in both builds.

## Structure
- A shared package holds:
  - opcode constants: ADD through HLT, class codes, LI/ADDI sub-codes;
  - the EXEC_PHASE = 3'b010 constant;
  - the state encoding.
- One sub-module, p3_alu: the combinational ALU and flag generation for non-shift ops.
- The shifter and FSM stay in p3_execute.

## Test plan
- ADD: br = 0x7FFF, ar = 0x0001 -> dr = 0x8000, S = 1, Z = 0, C = 0, V = 1, after 1 cycle.
- SUB: br = 0x0001, ar = 0x0002 -> dr = 0xFFFF, C = 1, S = 1. CMP with the same operands -> dr unchanged, same flags.
- Serial SRA: d = 4, br = 0x8010 -> exec_busy high for 3 cycles, dr = 0xF801, C = 0. Phase held at 010 for 10 cycles -> no re-execution.
- SLR: d = 1, br = 0x8001 -> dr = 0x0003, C = 1, busy never high. d = 0 -> dr = br, C = 0.
- LD: br = 0x0100, IR[7:0] = 0xFE -> dr = 0x00FE, flags unchanged. OUT: ar = 0x1234 -> out_port = 0x1234, single-cycle out_strobe.
- Reset asserted in the 2nd cycle of a d = 8 serial shift -> next cycle IDLE, dr = 0, exec_busy = 0. HLT -> halt stays 1 until reset.
